memory_turn_judge: RTL and testbench

Turn and scoring engine for the two-player 4×4 memory card game. It sits downstream of the cursor and selection controls. It consumes one selection pulse per card flip, along with the grid position and the 3-bit card value read at that position. It pairs two flips into a turn, holds both cards visible for a fixed time, then records a match or passes the turn. It tracks matched cells, per-player scores, the active player, turn-timer restarts, and game end.

---
 rtl/memory_turn_judge.sv | 165 ++++++++++++++++
 tb/tb_memory_turn_judge.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/memory_turn_judge.sv
// rtl/memory_turn_judge.sv - two-player 4x4 memory game turn pairing, reveal hold and scoring
module memory_turn_judge #(
  parameter int SHOW_CYCLES = 25_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sel_valid,
  input  logic [1:0]  sel_x,
  input  logic [1:0]  sel_y,
  input  logic [2:0]  card_value,
  input  logic        timeout,
  output logic        player,
  output logic [3:0]  score0,
  output logic [3:0]  score1,
  output logic [15:0] matched,
  output logic [3:0]  first_idx,
  output logic [3:0]  second_idx,
  output logic        first_shown,
  output logic        second_shown,
  output logic        turn_restart,
  output logic        game_over,
  output logic [1:0]  winner
);

  localparam int CW = (SHOW_CYCLES > 1) ? $clog2(SHOW_CYCLES) : 1;

  typedef enum logic [1:0] {WAIT_FIRST, WAIT_SECOND, SHOW, DONE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    first_val_q, first_val_d;
  logic          match_q, match_d;
  logic          player_q, player_d;
  logic [3:0]    score0_q, score0_d, score1_q, score1_d;
  logic [15:0]   matched_q, matched_d;
  logic [3:0]    first_idx_q, first_idx_d, second_idx_q, second_idx_d;
  logic          first_shown_q, first_shown_d, second_shown_q, second_shown_d;
  logic          restart_q, restart_d;
  logic          game_over_q, game_over_d;
  logic [1:0]    winner_q, winner_d;

  logic [3:0] sel_idx;
  logic       sel_ok;

  assign sel_idx = {sel_x, sel_y};
  assign sel_ok  = sel_valid && !timeout && !matched_q[sel_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= WAIT_FIRST;
      cnt_q          <= '0;
      first_val_q    <= '0;
      match_q        <= 1'b0;
      player_q       <= 1'b0;
      score0_q       <= '0;
      score1_q       <= '0;
      matched_q      <= '0;
      first_idx_q    <= '0;
      second_idx_q   <= '0;
      first_shown_q  <= 1'b0;
      second_shown_q <= 1'b0;
      restart_q      <= 1'b0;
      game_over_q    <= 1'b0;
      winner_q       <= 2'b00;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      first_val_q    <= first_val_d;
      match_q        <= match_d;
      player_q       <= player_d;
      score0_q       <= score0_d;
      score1_q       <= score1_d;
      matched_q      <= matched_d;
      first_idx_q    <= first_idx_d;
      second_idx_q   <= second_idx_d;
      first_shown_q  <= first_shown_d;
      second_shown_q <= second_shown_d;
      restart_q      <= restart_d;
      game_over_q    <= game_over_d;
      winner_q       <= winner_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    first_val_d    = first_val_q;
    match_d        = match_q;
    player_d       = player_q;
    score0_d       = score0_q;
    score1_d       = score1_q;
    matched_d      = matched_q;
    first_idx_d    = first_idx_q;
    second_idx_d   = second_idx_q;
    first_shown_d  = first_shown_q;
    second_shown_d = second_shown_q;
    restart_d      = 1'b0;
    game_over_d    = game_over_q;
    winner_d       = winner_q;

    case (state_q)
      WAIT_FIRST, WAIT_SECOND: begin
        if (timeout) begin
          player_d       = ~player_q;
          first_shown_d  = 1'b0;
          second_shown_d = 1'b0;
          restart_d      = 1'b1;
          state_d        = WAIT_FIRST;
        end else if (sel_ok && state_q == WAIT_FIRST) begin
          first_idx_d   = sel_idx;
          first_val_d   = card_value;
          first_shown_d = 1'b1;
          state_d       = WAIT_SECOND;
        end else if (sel_ok && sel_idx != first_idx_q) begin
          second_idx_d   = sel_idx;
          second_shown_d = 1'b1;
          match_d        = (card_value == first_val_q);
          cnt_d          = CW'(SHOW_CYCLES - 1);
          state_d        = SHOW;
        end
      end
      SHOW: begin
        if (cnt_q == '0) begin
          if (match_q) begin
            matched_d[first_idx_q]  = 1'b1;
            matched_d[second_idx_q] = 1'b1;
            if (player_q) score1_d = score1_q + 4'd1;
            else          score0_d = score0_q + 4'd1;
          end else begin
            player_d = ~player_q;
          end
          first_shown_d  = 1'b0;
          second_shown_d = 1'b0;
          restart_d      = 1'b1;
          if (&matched_d) begin
            // Final standings are latched at the same edge the game ends.
            state_d     = DONE;
            game_over_d = 1'b1;
            if (score0_d > score1_d)      winner_d = 2'b01;
            else if (score1_d > score0_d) winner_d = 2'b10;
            else                          winner_d = 2'b11;
          end else begin
            state_d = WAIT_FIRST;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  assign player       = player_q;
  assign score0       = score0_q;
  assign score1       = score1_q;
  assign matched      = matched_q;
  assign first_idx    = first_idx_q;
  assign second_idx   = second_idx_q;
  assign first_shown  = first_shown_q;
  assign second_shown = second_shown_q;
  assign turn_restart = restart_q;
  assign game_over    = game_over_q;
  assign winner       = winner_q;

endmodule

// File: tb/tb_memory_turn_judge.sv
// tb/tb_memory_turn_judge.sv - scoreboard bench for memory_turn_judge with a reveal-deadline game model
module tb_memory_turn_judge;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sel_valid = 1'b0;
  logic [1:0]  sel_x = '0, sel_y = '0;
  logic [2:0]  card_value = '0;
  logic        timeout = 1'b0;
  logic        player, first_shown, second_shown, turn_restart, game_over;
  logic [3:0]  score0, score1, first_idx, second_idx;
  logic [15:0] matched;
  logic [1:0]  winner;

  memory_turn_judge #(.SHOW_CYCLES(SC)) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_x(sel_x), .sel_y(sel_y),
    .card_value(card_value), .timeout(timeout), .player(player), .score0(score0),
    .score1(score1), .matched(matched), .first_idx(first_idx), .second_idx(second_idx),
    .first_shown(first_shown), .second_shown(second_shown), .turn_restart(turn_restart),
    .game_over(game_over), .winner(winner)
  );

  always #5 clk = ~clk;

  int cycle_n = 0;
  always @(posedge clk) cycle_n <= cycle_n + 1;

  typedef struct {
    int          cyc;
    logic [38:0] v;
  } snap_t;
  snap_t sb[$];

  int total = 0;
  int bad = 0;

  // Reference game: cells as an array, the reveal as a deadline cycle.
  bit       m_cell[16];
  int       m_score[2];
  bit       m_pl, m_fs, m_ss, m_mt, m_done, m_restart;
  int       m_fi, m_si, m_fv, m_show_end;
  int       deck[16];

  function automatic void model_reset();
    foreach (m_cell[i]) m_cell[i] = 0;
    m_score[0] = 0; m_score[1] = 0;
    m_pl = 0; m_fs = 0; m_ss = 0; m_mt = 0; m_done = 0;
    m_fi = 0; m_si = 0; m_fv = 0; m_show_end = -1;
  endfunction

  function automatic logic [38:0] model_vec();
    logic [15:0] mm;
    logic [1:0]  w;
    int          n = 0;
    for (int i = 0; i < 16; i++) mm[i] = m_cell[i];
    w = 2'b00;
    if (m_done) begin
      if (m_score[0] > m_score[1])      w = 2'b01;
      else if (m_score[1] > m_score[0]) w = 2'b10;
      else                              w = 2'b11;
    end
    n = m_score[0];
    return {m_pl, 4'(n), 4'(m_score[1]), mm, 4'(m_fi), 4'(m_si),
            m_fs, m_ss, m_restart, m_done, w};
  endfunction

  function automatic void model_step(int p, bit r, bit sv, int idx, int v, bit to);
    bit all;
    m_restart = 0;
    if (r) begin
      model_reset();
    end else if (m_done) begin
    end else if (m_show_end >= 0) begin
      if (p == m_show_end) begin
        if (m_mt) begin
          m_cell[m_fi] = 1; m_cell[m_si] = 1;
          m_score[m_pl] = m_score[m_pl] + 1;
        end else begin
          m_pl = !m_pl;
        end
        m_fs = 0; m_ss = 0; m_restart = 1; m_show_end = -1;
        all = 1;
        foreach (m_cell[i]) if (!m_cell[i]) all = 0;
        m_done = all;
      end
    end else if (to) begin
      m_pl = !m_pl; m_fs = 0; m_ss = 0; m_restart = 1;
    end else if (sv && !m_cell[idx] && !(m_fs && idx == m_fi)) begin
      if (!m_fs) begin
        m_fi = idx; m_fv = v; m_fs = 1;
      end else begin
        m_si = idx; m_ss = 1; m_mt = (v == m_fv); m_show_end = p + SC;
      end
    end
  endfunction

  task automatic cyc(input bit r, input bit sv, input int idx, input int v, input bit to);
    snap_t s;
    @(negedge clk);
    rst = r; sel_valid = sv; timeout = to;
    sel_x = 2'(idx / 4); sel_y = 2'(idx % 4); card_value = 3'(v);
    model_step(cycle_n + 1, r, sv, idx, v, to);
    s.cyc = cycle_n + 1;
    s.v   = model_vec();
    sb.push_back(s);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0);
  endtask

  task automatic pick(input int idx);
    cyc(0, 1, idx, deck[idx], 0);
  endtask

  // Play one turn on pair cells a,b and let the reveal run out.
  task automatic turn(input int a, input int b);
    pick(a); pick(b); idle(SC + 1);
  endtask

  initial begin : monitor
    snap_t       s;
    logic [38:0] act;
    forever begin
      @(negedge clk);
      if (sb.size() > 0 && sb[0].cyc == cycle_n) begin
        s = sb.pop_front();
        act = {player, score0, score1, matched, first_idx, second_idx,
               first_shown, second_shown, turn_restart, game_over, winner};
        total++;
        if (act !== s.v) begin
          bad++;
          $display("FAIL outputs@cyc%0d actual=%h required=%h (pl,s0,s1,matched,fi,si,fs,ss,tr,go,win)",
                   cycle_n, act, s.v);
        end
      end
    end
  end

  initial begin : driver
    for (int i = 0; i < 16; i++) deck[i] = i / 2;
    model_reset();
    cyc(1, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    // match: (0,1)=idx1 and (3,3)=idx15 both value 3
    cyc(0, 1, 1, 3, 0); cyc(0, 1, 15, 3, 0); idle(SC + 1);
    // mismatch: (0,0) v0 then (1,0)=idx4 v6
    cyc(0, 1, 0, 0, 0); cyc(0, 1, 4, 6, 0); idle(SC + 1);
    // illegal: matched cell in WAIT_FIRST, reselect first, picks during SHOW
    cyc(0, 1, 1, 3, 0);
    cyc(0, 1, 2, 1, 0); cyc(0, 1, 2, 1, 0); cyc(0, 1, 3, 2, 0);
    cyc(0, 1, 5, 2, 0); cyc(0, 1, 6, 2, 1); idle(SC);
    // timeout in WAIT_SECOND with simultaneous selection
    cyc(0, 1, 5, 4, 0); cyc(0, 1, 6, 4, 1); idle(2);
    // reset on the 2nd SHOW cycle, then a fresh first pick
    cyc(0, 1, 7, 1, 0); cyc(0, 1, 8, 1, 0); idle(1);
    cyc(1, 0, 0, 0, 0);
    cyc(0, 1, 8, 1, 0); idle(2);

    // full game 5-3: p0 pairs 0..4, miss, p1 pairs 5..7
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 5; k++) turn(2 * k, 2 * k + 1);
    turn(10, 12);
    for (int k = 5; k < 8; k++) turn(2 * k, 2 * k + 1);
    cyc(0, 1, 0, 0, 0); cyc(0, 0, 0, 0, 1); idle(2);
    // full game 4-4 split
    cyc(1, 0, 0, 0, 0);
    for (int k = 0; k < 4; k++) turn(2 * k, 2 * k + 1);
    turn(8, 10);
    for (int k = 4; k < 8; k++) turn(2 * k, 2 * k + 1);
    idle(2);

    // randomized play with shuffled deck, back-to-back picks and rare resets
    cyc(1, 0, 0, 0, 0);
    for (int i = 15; i > 0; i--) begin
      int j, t;
      j = $urandom_range(i, 0);
      t = deck[i]; deck[i] = deck[j]; deck[j] = t;
    end
    for (int n = 0; n < 4000; n++) begin
      int  idx;
      bit  r, sv, to;
      idx = $urandom_range(15, 0);
      r   = ($urandom_range(599, 0) == 0);
      sv  = ($urandom_range(1, 0) == 1);
      to  = ($urandom_range(39, 0) == 0);
      if (m_done && $urandom_range(19, 0) == 0) r = 1;
      cyc(r, sv, idx, deck[idx], to);
    end
    idle(2);
    @(negedge clk);
    @(negedge clk);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL drain actual=%0d required=0 pending snapshots", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
